uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_pkg.sv | 19 +
 rtl/sync_fifo.sv | 83 ++++++++
 rtl/uart_tx_fifo.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   tx_state_e            : 2-bit serializer state encoding
//   DEFAULT_CLKS_PER_BIT  : 100 MHz / 115200 baud
//   DEFAULT_DEPTH         : default FIFO entries (power of two, >= 2)
//   UART_TX_ADDR          : CPU store address that feeds wr_en
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned DEFAULT_DEPTH        = 16;
  localparam logic [31:0] UART_TX_ADDR         = 32'h1000_0000;

endpackage

// File: rtl/sync_fifo.sv
// Circular byte FIFO with registered occupancy flags.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write request; ignored while full
//   pop       : read request; ignored while empty
//   wr_data   : byte written at the write pointer
//   rd_data   : byte at the read pointer (head of queue)
//   full      : DEPTH entries held
//   empty     : no entries held
//   count     : occupancy, 0..DEPTH
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  // Acceptance uses the registered flags, so a push while full is dropped
  // even when a pop frees a slot on the same edge.
  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer.
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : CPU store to the UART TX address
//   wr_data   : byte to transmit
//   ovf_clr   : clears the sticky overflow flag
//   uart_tx   : serial line, idle high, driven from a flop
//   full      : FIFO holds DEPTH entries
//   empty     : FIFO holds no entries
//   count     : FIFO occupancy
//   busy      : frame in progress or bytes queued
//   overflow  : sticky, set when a write was dropped
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DEPTH        = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   ovf_clr,
  output logic                   uart_tx,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   overflow
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;

  logic             fifo_pop;
  logic [7:0]       fifo_rd_data;
  logic             fifo_full, fifo_empty;
  logic             baud_done;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .pop     (fifo_pop),
    .wr_data (wr_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  assign baud_done = (baud_q == BAUD_LAST);

  // tx_d is the line level for the state being entered, so uart_tx comes
  // straight from a flop and changes exactly on the bit boundary.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_rd_data;
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_START;
          tx_d      = 1'b0;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d    = '0;
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (!fifo_empty) begin
            // Chain straight into the next frame with no idle bit.
            fifo_pop  = 1'b1;
            shift_d   = fifo_rd_data;
            bit_idx_d = '0;
            state_d   = ST_START;
            tx_d      = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // A drop sets the flag even when ovf_clr is asserted in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && fifo_full) ovf_d = 1'b1;
    else if (ovf_clr)       ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign uart_tx  = tx_q;
  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign busy     = (state_q != ST_IDLE) | ~fifo_empty;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with CLKS_PER_BIT=4, DEPTH=4. A frame-timing
// reference (queue of pending bytes, frame age in cycles) predicts every
// output after every edge.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       ovf_clr = 1'b0;
  logic       uart_tx, full, empty, busy, overflow;
  logic [2:0] count;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .ovf_clr  (ovf_clr),
    .uart_tx  (uart_tx),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .busy     (busy),
    .overflow (overflow)
  );

  // Reference state: queued bytes, byte on the wire, cycles since its start bit.
  logic [7:0] q[$];
  bit         in_flight = 1'b0;
  logic [7:0] cur = '0;
  int         age = 0;
  bit         m_ovf = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Line level from frame age: start bit, 8 data bits LSB first, stop bit.
  function automatic logic exp_tx();
    int p;
    if (!in_flight) return 1'b1;
    p = age / CPB;
    if (p == 0) return 1'b0;
    if (p <= 8) return cur[p-1];
    return 1'b1;
  endfunction

  task automatic step(input logic we, input logic [7:0] d, input logic clr, input logic r);
    bit was_full, was_empty, do_pop;
    rst     = r;
    wr_en   = we;
    wr_data = d;
    ovf_clr = clr;
    @(posedge clk);
    if (r) begin
      q.delete();
      in_flight = 1'b0;
      age       = 0;
      m_ovf     = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      do_pop    = 1'b0;
      if (in_flight) begin
        age++;
        if (age == 10 * CPB) begin
          in_flight = 1'b0;
          age       = 0;
          do_pop    = !was_empty;
        end
      end else begin
        do_pop = !was_empty;
      end
      if (we && was_full) m_ovf = 1'b1;
      else if (clr)       m_ovf = 1'b0;
      if (do_pop) begin
        cur       = q.pop_front();
        in_flight = 1'b1;
        age       = 0;
      end
      if (we && !was_full) q.push_back(d);
    end
    #1;
    chk("uart_tx",  {7'd0, uart_tx},  {7'd0, exp_tx()});
    chk("count",    {5'd0, count},    8'(q.size()));
    chk("full",     {7'd0, full},     {7'd0, q.size() == DEPTH});
    chk("empty",    {7'd0, empty},    {7'd0, q.size() == 0});
    chk("busy",     {7'd0, busy},     {7'd0, in_flight || q.size() != 0});
    chk("overflow", {7'd0, overflow}, {7'd0, m_ovf});
    rst     = 1'b0;
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((in_flight || q.size() != 0) && guard < 2000) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      guard++;
    end
    checks++;
    if (guard >= 2000) begin
      errors++;
      $display("FAIL drain_timeout: observed=busy required=idle");
    end
  endtask

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

    // Single 0xA5 frame
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(45);

    // Back-to-back frames
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    idle(85);

    // Six consecutive writes: one popped, four queued, sixth dropped
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    drain();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // Write held across a frame boundary: write-while-full with same-cycle pop,
    // then drop and ovf_clr together (set wins)
    for (int i = 0; i < 46; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'($urandom), 1'b1, 1'b0);
    drain();
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-frame with two bytes queued
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    idle(14);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(60);

    // Pointer wrap: 10 bytes in groups of 3 while draining
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 3 && g * 3 + i < 10; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      idle(30);
    end
    drain();

    // Random traffic, occasional clears and resets
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 15) == 0,
           $urandom_range(0, 299) == 0);
    drain();
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
